prio_enc_stream: RTL and testbench

Parametrised sequential priority encoder. Accepts a WIDTH-bit request vector over a valid/ready handshake and emits the index of every set bit, one index per output beat, in LSB-first or MSB-first order selected per vector. It sits between request-collecting logic and downstream consumers that service one request index at a time. It replaces the fixed 8-bit, single-result combinational encoder.

---
 rtl/prio_enc_pkg.sv | 14 +
 rtl/prio_find.sv | 27 ++
 rtl/prio_enc_stream.sv | 66 ++++++
 tb/tb_prio_enc_stream.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared types and helpers for the streaming priority encoder.
package prio_enc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // A width of 1 still needs a 1-bit index so ports never collapse to zero width.
    function automatic int idx_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/prio_find.sv
// prio_find: combinational find-first-set with selectable search direction.
module prio_find
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    input  logic             dir_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [WIDTH-1:0] rev;
    logic [IDX_W-1:0] lo;

    // Mirror the vector for MSB-first so one LSB-first search serves both orders.
    always_comb begin
        rev = '0;
        for (int i = 0; i < WIDTH; i++) rev[i] = dir_i ? vec_i[WIDTH-1-i] : vec_i[i];
        lo = '0;
        for (int i = WIDTH - 1; i >= 0; i--) if (rev[i]) lo = IDX_W'(i);
        any_o = |vec_i;
        idx_o = !any_o ? '0 : dir_i ? IDX_W'(WIDTH - 1) - lo : lo;
    end

endmodule

// File: rtl/prio_enc_stream.sv
// prio_enc_stream: emits the index of every set bit of each accepted vector,
// one beat per index, LSB-first or MSB-first per vector.
module prio_enc_stream
    import prio_enc_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             msb_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             dir_q, dir_d;
    logic [IDX_W-1:0] find_idx;
    logic             find_any, emit, one_left, accept, pop;

    prio_find #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_find (
        .vec_i (pend_q),
        .dir_i (dir_q),
        .idx_o (find_idx),
        .any_o (find_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            dir_q   <= dir_d;
        end
    end

    // A new vector overrides the return to IDLE when it lands on the last beat.
    always_comb begin
        accept  = in_valid && in_ready;
        pop     = out_valid && out_ready;
        state_d = accept ? EMIT : (pop && out_last) ? IDLE : state_q;
        pend_d  = accept ? in_vec : pop ? pend_q & ~(WIDTH'(1) << find_idx) : pend_q;
        dir_d   = accept ? msb_first : dir_q;
    end

    always_comb begin
        emit      = state_q == EMIT;
        one_left  = (pend_q & (pend_q - WIDTH'(1))) == '0;
        out_valid = emit;
        out_idx   = emit ? find_idx : '0;
        out_last  = emit && one_left;
        out_none  = emit && !find_any;
        in_ready  = !emit || (out_ready && one_left);
    end

endmodule

// File: tb/tb_prio_enc_stream.sv
// tb_prio_enc_stream: directed scoreboard bench for 8- and 16-bit encoders.
module tb_prio_enc_stream;

    typedef struct packed {
        logic [3:0] idx;
        logic       last;
        logic       none;
    } beat_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        iv8 = 1'b0, ms8 = 1'b0, or8 = 1'b1, ir8, ov8, last8, none8;
    logic [7:0]  v8 = '0;
    logic [2:0]  idx8;
    logic        iv16 = 1'b0, ms16 = 1'b0, or16 = 1'b1, ir16, ov16, last16, none16;
    logic [15:0] v16 = '0;
    logic [3:0]  idx16;
    beat_t       q8[$], q16[$];
    bit          acc8, acc16;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    prio_enc_stream #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_vec(v8), .msb_first(ms8),
        .out_valid(ov8), .out_ready(or8), .out_idx(idx8), .out_last(last8), .out_none(none8)
    );

    prio_enc_stream #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_vec(v16), .msb_first(ms16),
        .out_valid(ov16), .out_ready(or16), .out_idx(idx16), .out_last(last16), .out_none(none16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic make_beats(input int w, input logic [15:0] v, input logic d, output beat_t b[$]);
        int n = $countones(v);
        b = {};
        if (n == 0) b.push_back('{idx: 4'd0, last: 1'b1, none: 1'b1});
        else for (int k = 0; k < w; k++) begin
            int j = d ? w - 1 - k : k;
            if (v[j]) begin
                n--;
                b.push_back('{idx: 4'(j), last: (n == 0), none: 1'b0});
            end
        end
    endtask

    // Checks one DUT against its queue: outstanding beats imply out_valid, head must match.
    task automatic side(input int s, input logic ov, input logic ir, input logic [3:0] idx,
                        input logic last, input logic none, input logic ordy, input logic iv,
                        input logic [15:0] v, input logic d, input int w, output bit acc);
        int    sz = s ? q16.size() : q8.size();
        beat_t h  = (sz == 0) ? '0 : s ? q16[0] : q8[0];
        beat_t nb[$];
        acc = 1'b0;
        chk($sformatf("w%0d out_valid", w), 32'(ov), 32'(sz != 0));
        chk($sformatf("w%0d in_ready", w), 32'(ir), 32'(sz == 0 || (ordy && sz == 1)));
        chk($sformatf("w%0d beat", w), 32'({idx, last, none}), ov ? 32'(h) : 32'd0);
        if (rst) begin
            if (s) q16.delete(); else q8.delete();
        end else begin
            if (ov && ordy && sz != 0) begin
                if (s) void'(q16.pop_front()); else void'(q8.pop_front());
            end
            if (iv && ir) begin
                acc = 1'b1;
                make_beats(w, v, d, nb);
                foreach (nb[k]) if (s) q16.push_back(nb[k]); else q8.push_back(nb[k]);
            end
        end
    endtask

    task automatic cyc();
        bit a;
        @(negedge clk);
        side(0, ov8, ir8, {1'b0, idx8}, last8, none8, or8, iv8, {8'h00, v8}, ms8, 8, a);
        acc8 = a;
        side(1, ov16, ir16, idx16, last16, none16, or16, iv16, v16, ms16, 16, a);
        acc16 = a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic send8(input logic [7:0] v, input logic d);
        bit done = 1'b0;
        iv8 = 1'b1; v8 = v; ms8 = d;
        for (int i = 0; i < 20 && !done; i++) begin
            cyc();
            done = acc8;
        end
        iv8 = 1'b0;
        chk("w8 accept", 32'(done), 32'd1);
    endtask

    task automatic send16(input logic [15:0] v, input logic d);
        bit done = 1'b0;
        iv16 = 1'b1; v16 = v; ms16 = d;
        for (int i = 0; i < 20 && !done; i++) begin
            cyc();
            done = acc16;
        end
        iv16 = 1'b0;
        chk("w16 accept", 32'(done), 32'd1);
    endtask

    initial begin
        // vector offered during reset must never produce beats
        iv8 = 1'b1; v8 = 8'hFF;
        idle(2);
        rst = 1'b0; iv8 = 1'b0;
        idle(2);
        send8(8'hA4, 1'b0);
        idle(4);
        send8(8'hA4, 1'b1);
        idle(4);
        send8(8'h00, 1'b0);
        idle(2);
        or8 = 1'b0;
        send8(8'h81, 1'b0);
        idle(3);
        or8 = 1'b1;
        idle(3);
        send8(8'h03, 1'b0);
        send8(8'h80, 1'b1);
        idle(3);
        send8(8'hFF, 1'b0);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        idle(4);
        send16(16'h8001, 1'b0);
        idle(3);
        send16(16'h8001, 1'b1);
        idle(3);
        chk("w8 drained", 32'(q8.size()), 32'd0);
        chk("w16 drained", 32'(q16.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
